// File: rtl/adc_sar_control.sv
// ---------------------------------------------------------------------------
// adc_sar_control
//
// Successive-approximation controller for the 12-bit capacitive SAR ADC.
// It runs a sample phase, then resolves one bit per cycle (MSB first) from
// the comparator decision. It drives the trial code into the row/column
// thermometer decoder and returns the final binary word over a valid/ready
// handshake.
//
// Ports:
//   clk           block clock, rising edge
//   rst_n         asynchronous active-low reset
//   start         conversion request (looked at only in IDLE)
//   sample_len    sample phase lasts sample_len+1 cycles (latched at start)
//   comp_in       comparator decision, 1 = input >= trial level
//   busy          high in SAMPLE and CONV
//   sample_out    high during SAMPLE (input switches closed)
//   comp_en       comparator strobe, high in every CONV cycle
//   dac_code      trial code to the decoder data_in[11:0]
//   result        last completed conversion
//   result_valid  result available
//   result_ready  consumer accepts result
//
// Handshake: result_valid rises on the edge that resolves the last bit and
// holds, with result stable, until an edge where result_ready=1. A
// completion on that same edge wins and keeps result_valid high. A new
// conversion starts only when the result slot is free (result_valid=0) or
// is being freed on that edge (result_ready=1). Therefore no result is ever
// overwritten before the consumer accepts it.
// ---------------------------------------------------------------------------
module adc_sar_control (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [3:0]  sample_len,
   input  logic        comp_in,
   output logic        busy,
   output logic        sample_out,
   output logic        comp_en,
   output logic [11:0] dac_code,
   output logic [11:0] result,
   output logic        result_valid,
   input  logic        result_ready
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SAMPLE = 2'd1,
      CONV   = 2'd2
   } state_t;

   state_t      state;        // FSM state; bind checkers here
   logic [3:0]  bit_idx;      // bit k currently being resolved
   logic [3:0]  sample_cnt;   // remaining SAMPLE cycles minus one

   logic        start_ok;
   logic [11:0] code_decided;    // trial code with bit k replaced by comp_in
   logic [11:0] code_next_trial; // decided bits, then 1 at k-1, then zeros

   always_comb begin
      start_ok = start && (!result_valid || result_ready);
   end

   // The current trial already holds zeros below bit k. Writing the decision
   // into bit k and setting bit k-1 therefore gives the next trial directly.
   always_comb begin
      code_decided          = dac_code;
      code_decided[bit_idx] = comp_in;
      code_next_trial       = code_decided;
      if (bit_idx != 4'd0) begin
         code_next_trial[bit_idx - 4'd1] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         bit_idx      <= 4'd11;
         sample_cnt   <= 4'd0;
         busy         <= 1'b0;
         sample_out   <= 1'b0;
         comp_en      <= 1'b0;
         dac_code     <= 12'h000;
         result       <= 12'h000;
         result_valid <= 1'b0;
      end else begin
         // Acceptance clears the flag. A completion on the same edge
         // overrides this below.
         if (result_ready) begin
            result_valid <= 1'b0;
         end

         case (state)
            IDLE: begin
               if (start_ok) begin
                  state      <= SAMPLE;
                  sample_cnt <= sample_len;
                  dac_code   <= 12'h800;
                  busy       <= 1'b1;
                  sample_out <= 1'b1;
               end
            end

            SAMPLE: begin
               if (sample_cnt == 4'd0) begin
                  state      <= CONV;
                  bit_idx    <= 4'd11;
                  sample_out <= 1'b0;
                  comp_en    <= 1'b1;
               end else begin
                  sample_cnt <= sample_cnt - 4'd1;
               end
            end

            CONV: begin
               if (bit_idx != 4'd0) begin
                  dac_code <= code_next_trial;
                  bit_idx  <= bit_idx - 4'd1;
               end else begin
                  result       <= code_decided;
                  result_valid <= 1'b1;
                  state        <= IDLE;
                  dac_code     <= 12'h000;
                  busy         <= 1'b0;
                  comp_en      <= 1'b0;
                  bit_idx      <= 4'd11;
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_adc_sar_control.sv
// ---------------------------------------------------------------------------
// tb_adc_sar_control
//
// Directed-plus-random bench for adc_sar_control. A reference model derives
// the expected trial sequence and result for each conversion. The model
// builds the trial codes as a binary search (decided upper bits | 1<<k). It
// takes the decisions from an ideal comparator (vin >= trial), from random
// bits, or from a comparator tied to 1 or to 0.
// ---------------------------------------------------------------------------
module tb_adc_sar_control;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [3:0]  sample_len;
   logic        comp_in;
   logic        busy;
   logic        sample_out;
   logic        comp_en;
   logic [11:0] dac_code;
   logic [11:0] result;
   logic        result_valid;
   logic        result_ready;

   int vectors     = 0;
   int miscompares = 0;

   adc_sar_control dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .sample_len   (sample_len),
      .comp_in      (comp_in),
      .busy         (busy),
      .sample_out   (sample_out),
      .comp_en      (comp_en),
      .dac_code     (dac_code),
      .result       (result),
      .result_valid (result_valid),
      .result_ready (result_ready)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   // Called at a negedge. Presents start for one edge and returns at the
   // following negedge, with the DUT in the first SAMPLE cycle.
   task automatic accept(input int sl);
      start      = 1'b1;
      sample_len = 4'(sl);
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
   endtask

   // mode: 0 ideal comparator on vin, 1 random decisions, 2 tied 1, 3 tied 0.
   // abort_j: return just before driving CONV step abort_j (k = 11-abort_j).
   task automatic run_body(input logic [11:0] vin, input int sl, input int mode,
                           input bit perturb, input int abort_j,
                           output logic [11:0] exp_out);
      logic [11:0] trial_q [12];
      logic        dec_q   [12];
      logic [11:0] decided;
      int          k;
      int          n_samp;

      // Reference model: binary search over the 12-bit code.
      decided = 12'h000;
      for (int j = 0; j < 12; j++) begin
         k          = 11 - j;
         trial_q[j] = decided | (12'(1) << k);
         case (mode)
            0:       dec_q[j] = (vin >= trial_q[j]);
            1:       dec_q[j] = 1'($urandom_range(0, 1));
            2:       dec_q[j] = 1'b1;
            default: dec_q[j] = 1'b0;
         endcase
         if (dec_q[j]) decided = decided | (12'(1) << k);
      end
      // An ideal SAR reproduces its input exactly.
      exp_out = (mode == 0) ? vin : decided;

      // SAMPLE phase, bounded.
      n_samp = 0;
      while (sample_out === 1'b1 && n_samp < 40) begin
         check("sample_dac", dac_code, 12'h800);
         check("sample_busy", busy, 1);
         if (perturb) begin
            start      = 1'($urandom_range(0, 1));
            sample_len = 4'($urandom_range(0, 15));
         end
         n_samp++;
         @(posedge clk);
         @(negedge clk);
      end
      check("sample_width", n_samp, sl + 1);

      // CONV phase: one decision per cycle.
      for (int j = 0; j < 12; j++) begin
         check("conv_comp_en", comp_en, 1);
         check("conv_dac", dac_code, trial_q[j]);
         check("conv_busy", busy, 1);
         if (j == 11) check("conv_valid_low", result_valid, 0);
         if (j == abort_j) return;
         comp_in = dec_q[j];
         if (perturb) begin
            start      = 1'($urandom_range(0, 1));
            sample_len = 4'($urandom_range(0, 15));
         end
         @(posedge clk);
         @(negedge clk);
      end
      start = 1'b0;

      // The latency check is implicit here: sample_len+1 SAMPLE edges plus
      // 12 CONV edges. result_valid must be up now.
      check("done_valid", result_valid, 1);
      check("done_result", result, exp_out);
      check("done_busy", busy, 0);
      check("done_dac", dac_code, 12'h000);
      check("done_comp_en", comp_en, 0);
   endtask

   // With result_ready=1, valid drops one edge later and result holds.
   task automatic post_accept(input logic [11:0] exp);
      @(posedge clk);
      @(negedge clk);
      check("post_valid_low", result_valid, 0);
      check("post_result_hold", result, exp);
      check("post_idle_dac", dac_code, 12'h000);
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #500000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   // ---------------- stimulus / scoreboard ----------------
   logic [11:0] exp_q [$];
   logic [11:0] exp_r;
   logic [11:0] vin_r;
   int          sl_r;
   int          mode_r;

   initial begin
      rst_n        = 1'b0;
      start        = 1'b0;
      sample_len   = 4'd0;
      comp_in      = 1'b0;
      result_ready = 1'b1;
      repeat (3) @(negedge clk);

      check("rst_busy", busy, 0);
      check("rst_sample_out", sample_out, 0);
      check("rst_comp_en", comp_en, 0);
      check("rst_dac", dac_code, 12'h000);
      check("rst_result", result, 12'h000);
      check("rst_valid", result_valid, 0);

      rst_n = 1'b1;
      @(negedge clk);
      check("idle_busy", busy, 0);

      // Directed: ideal comparator, vin=A5C, sample_len=3.
      accept(3);
      run_body(12'hA5C, 3, 0, 1'b0, 99, exp_r);
      check("a5c_result", result, 12'hA5C);
      post_accept(exp_r);

      // Corner codes with minimum and maximum sample length.
      accept(0);
      run_body(12'h000, 0, 2, 1'b0, 99, exp_r);
      check("tied1_result", result, 12'hFFF);
      post_accept(exp_r);
      accept(15);
      run_body(12'hFFF, 15, 3, 1'b0, 99, exp_r);
      check("tied0_result", result, 12'h000);
      post_accept(exp_r);

      // Backpressure: the result is held while start stays high.
      result_ready = 1'b0;
      accept(2);
      run_body(12'h123, 2, 0, 1'b0, 99, exp_r);
      start      = 1'b1;
      sample_len = 4'd5;
      repeat (6) begin
         check("bp_no_sample", sample_out, 0);
         check("bp_busy", busy, 0);
         check("bp_result", result, 12'h123);
         check("bp_valid", result_valid, 1);
         @(posedge clk);
         @(negedge clk);
      end
      result_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      result_ready = 1'b0;
      start        = 1'b0;
      check("bp_accept_valid_low", result_valid, 0);
      check("bp_accept_sampling", sample_out, 1);
      run_body(12'h456, 5, 0, 1'b0, 99, exp_r);
      check("bp_second_result", result, 12'h456);
      result_ready = 1'b1;
      post_accept(exp_r);

      // Reset in the middle of CONV, with k=5 being resolved.
      accept(4);
      run_body(12'h3C5, 4, 0, 1'b0, 6, exp_r);
      rst_n = 1'b0;
      #1;
      check("arst_busy", busy, 0);
      check("arst_comp_en", comp_en, 0);
      check("arst_dac", dac_code, 12'h000);
      check("arst_valid", result_valid, 0);
      check("arst_result", result, 12'h000);
      #2;
      rst_n   = 1'b1;
      comp_in = 1'b0;
      @(negedge clk);
      check("arst_idle", busy, 0);
      accept(1);
      run_body(12'h7FF, 1, 0, 1'b0, 99, exp_r);
      check("arst_fresh_result", result, 12'h7FF);
      post_accept(exp_r);

      // start and sample_len are toggled during SAMPLE and CONV.
      accept(7);
      run_body(12'($urandom), 7, 0, 1'b1, 99, exp_r);
      post_accept(exp_r);

      // Random conversions, checked against the scoreboard queue.
      repeat (20) begin
         vin_r  = 12'($urandom);
         sl_r   = $urandom_range(0, 15);
         mode_r = $urandom_range(0, 1);
         accept(sl_r);
         run_body(vin_r, sl_r, mode_r, 1'($urandom_range(0, 1)), 99, exp_r);
         exp_q.push_back(exp_r);
         post_accept(exp_q.pop_front());
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
